// File: rtl/text_console.sv
// Character-cell console: prints bytes into a 32x24 text VRAM,
// with CR/LF/BS/FF handling, line wrap, hardware scroll and clear.
module text_console (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] vram_addr,
  output logic [7:0] vram_wdata,
  output logic       vram_we,
  input  logic [7:0] vram_rdata,
  output logic [4:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  typedef enum logic [2:0] {
    CLEAR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL
  } state_t;

  localparam logic [4:0] LAST_COL  = 5'd31;
  localparam logic [4:0] LAST_ROW  = 5'd23;
  localparam logic [9:0] LAST_CELL = 10'd767;
  localparam logic [9:0] ROW1      = 10'd32;
  localparam logic [9:0] ROW23     = 10'd736;
  localparam logic [7:0] SPACE     = 8'h20;

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [4:0] col, col_n;
  logic [4:0] row, row_n;
  logic [7:0] data, data_n;
  logic       adv, adv_n;

  logic is_cr, is_lf, is_bs, is_ff;

  assign is_cr = in_data == 8'h0D;
  assign is_lf = in_data == 8'h0A;
  assign is_bs = in_data == 8'h08;
  assign is_ff = in_data == 8'h0C;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
      data  <= '0;
      adv   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      col   <= col_n;
      row   <= row_n;
      data  <= data_n;
      adv   <= adv_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    col_n      = col;
    row_n      = row;
    data_n     = data;
    adv_n      = adv;
    vram_addr  = '0;
    vram_wdata = '0;
    vram_we    = 1'b0;
    in_ready   = 1'b0;
    unique case (state)
      CLEAR: begin
        vram_addr  = cnt;
        vram_wdata = SPACE;
        vram_we    = 1'b1;
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
          col_n   = '0;
          row_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          unique case (1'b1)
            is_cr: col_n = '0;
            is_lf: begin
              if (row == LAST_ROW) begin
                state_n = SCROLL_RD;
                cnt_n   = ROW1;
              end else begin
                row_n = row + 5'd1;
              end
            end
            is_bs: begin
              if (col != '0) begin
                col_n   = col - 5'd1;
                data_n  = SPACE;
                adv_n   = 1'b0;
                state_n = WRITE;
              end
            end
            is_ff: begin
              state_n = CLEAR;
              cnt_n   = '0;
            end
            default: begin
              data_n  = in_data;
              adv_n   = 1'b1;
              state_n = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        vram_addr  = {row, col};
        vram_wdata = data;
        vram_we    = 1'b1;
        state_n    = IDLE;
        if (adv) begin
          if (col != LAST_COL) begin
            col_n = col + 5'd1;
          end else begin
            col_n = '0;
            if (row != LAST_ROW) begin
              row_n = row + 5'd1;
            end else begin
              state_n = SCROLL_RD;
              cnt_n   = ROW1;
            end
          end
        end
      end
      SCROLL_RD: begin
        vram_addr = cnt;
        state_n   = SCROLL_WR;
      end
      SCROLL_WR: begin
        // rdata now holds the word read one row below this address
        vram_addr  = cnt - ROW1;
        vram_wdata = vram_rdata;
        vram_we    = 1'b1;
        if (cnt == LAST_CELL) begin
          state_n = FILL;
          cnt_n   = ROW23;
        end else begin
          state_n = SCROLL_RD;
          cnt_n   = cnt + 10'd1;
        end
      end
      FILL: begin
        vram_addr  = cnt;
        vram_wdata = SPACE;
        vram_we    = 1'b1;
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end
      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase
    if (reset) begin
      vram_we  = 1'b0;
      in_ready = 1'b0;
    end
  end

  assign busy       = ~in_ready;
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: behavioural screen model, registered RAM
// model, directed corner cases and a randomized byte stream.
module tb_text_console;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] vram_addr;
  logic [7:0] vram_wdata;
  logic       vram_we;
  logic [7:0] vram_rdata;
  logic [4:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_console dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_rdata (vram_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:1023];

  always @(posedge clock) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  int bad_addr = 0;
  int bad_idle = 0;
  int bad_busy = 0;
  int wr_cnt = 0;
  int nready_cnt = 0;

  always @(negedge clock) begin
    if (vram_we && vram_addr >= 10'd768) bad_addr++;
    if (vram_we && in_ready) bad_idle++;
    if (busy === in_ready) bad_busy++;
    if (vram_we) wr_cnt++;
    if (!in_ready) nready_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference screen: 24 rows of 32 cells, row-major
  logic [7:0] scr [0:767];
  int mc = 0;
  int mr = 0;

  task automatic m_clear();
    for (int i = 0; i < 768; i++) scr[i] = 8'h20;
    mc = 0;
    mr = 0;
  endtask

  task automatic m_scroll();
    for (int i = 0; i < 736; i++) scr[i] = scr[i + 32];
    for (int i = 736; i < 768; i++) scr[i] = 8'h20;
  endtask

  task automatic m_apply(logic [7:0] b);
    case (b)
      8'h0D: mc = 0;
      8'h0A: if (mr < 23) mr++; else m_scroll();
      8'h08: if (mc > 0) begin mc--; scr[mr*32+mc] = 8'h20; end
      8'h0C: m_clear();
      default: begin
        scr[mr*32+mc] = b;
        if (mc < 31) mc++;
        else begin
          mc = 0;
          if (mr < 23) mr++; else m_scroll();
        end
      end
    endcase
  endtask

  function automatic int screen_diff();
    int d = 0;
    for (int i = 0; i < 768; i++) if (mem[i] !== scr[i]) d++;
    return d;
  endfunction

  function automatic logic [7:0] rand_print();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b inside {8'h08, 8'h0A, 8'h0C, 8'h0D});
    return b;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("idle_timeout", int'(in_ready), 1);
  endtask

  task automatic send(logic [7:0] b);
    wait_idle();
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic check_cursor(string tag, int c, int r);
    check({tag, "_col"}, int'(cursor_col), c);
    check({tag, "_row"}, int'(cursor_row), r);
  endtask

  task automatic do_op(logic [7:0] b);
    send(b);
    m_apply(b);
    wait_idle();
    check_cursor("op", mc, mr);
    check("screen", screen_diff(), 0);
  endtask

  task automatic do_reset();
    int bad = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_we", int'(vram_we), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 1);
    @(negedge clock);
    check("rst_we2", int'(vram_we), 0);
    check_cursor("rst", 0, 0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 768; i++) begin
      if (!(vram_we === 1'b1 && vram_addr === 10'(i) &&
            vram_wdata === 8'h20)) bad++;
      if (in_ready !== 1'b0) bad++;
      @(negedge clock);
    end
    check("clear_seq", bad, 0);
    check("clear_ready", int'(in_ready), 1);
    check_cursor("clear", 0, 0);
    m_clear();
    @(negedge clock);
    check("clear_mem", screen_diff(), 0);
  endtask

  initial begin
    int n;
    int w0;
    int r0;
    logic [7:0] b;

    do_reset();

    // first printable at home position
    in_data  = 8'h41;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("a_we", int'(vram_we), 1);
    check("a_addr", int'(vram_addr), 0);
    check("a_data", int'(vram_wdata), 8'h41);
    m_apply(8'h41);
    wait_idle();
    check_cursor("a", 1, 0);

    // wrap at bottom-right corner triggers a scroll
    do_op(8'h0C);
    for (int i = 0; i < 23; i++) do_op(8'h0A);
    for (int i = 0; i < 31; i++) do_op(rand_print());
    check_cursor("corner", 31, 23);
    wait_idle();
    in_data  = 8'hC1;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("c1_we", int'(vram_we), 1);
    check("c1_addr", int'(vram_addr), 10'h2FF);
    check("c1_data", int'(vram_wdata), 8'hC1);
    m_apply(8'hC1);
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check("scroll_len", n, 1504);
    check_cursor("scroll", 0, 23);
    check("scroll_mem", screen_diff(), 0);

    // CR then LF: cursor moves, no writes, never busy
    do_op(8'h0C);
    for (int i = 0; i < 3; i++) do_op(8'h0A);
    for (int i = 0; i < 5; i++) do_op(rand_print());
    check_cursor("crlf_pre", 5, 3);
    @(negedge clock);
    #1;
    w0 = wr_cnt;
    r0 = nready_cnt;
    send(8'h0D);
    send(8'h0A);
    m_apply(8'h0D);
    m_apply(8'h0A);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("crlf_writes", wr_cnt - w0, 0);
    check("crlf_busy", nready_cnt - r0, 0);
    check_cursor("crlf", 0, 4);

    // backspace at column 0 and at column 4
    do_op(8'h0C);
    do_op(8'h0A);
    do_op(8'h0A);
    @(negedge clock);
    #1;
    w0 = wr_cnt;
    send(8'h08);
    @(negedge clock);
    #1;
    check("bs0_writes", wr_cnt - w0, 0);
    check("bs0_ready", int'(in_ready), 1);
    check_cursor("bs0", 0, 2);
    for (int i = 0; i < 4; i++) do_op(rand_print());
    wait_idle();
    in_data  = 8'h08;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("bs_we", int'(vram_we), 1);
    check("bs_addr", int'(vram_addr), 10'h043);
    check("bs_data", int'(vram_wdata), 8'h20);
    m_apply(8'h08);
    wait_idle();
    check_cursor("bs", 3, 2);
    check("bs_mem", screen_diff(), 0);

    // reset in the middle of a scroll
    do_op(8'h0C);
    for (int i = 0; i < 23; i++) do_op(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 500; i++) @(negedge clock);
    check("mid_busy", int'(in_ready), 0);
    do_reset();

    // randomized stream, starting near the bottom to provoke scrolls
    for (int i = 0; i < 20; i++) do_op(8'h0A);
    for (int i = 0; i < 120; i++) begin
      n = $urandom_range(0, 99);
      if (n < 70) b = rand_print();
      else if (n < 80) b = 8'h0A;
      else if (n < 87) b = 8'h0D;
      else if (n < 97) b = 8'h08;
      else b = 8'h0C;
      do_op(b);
    end

    check("bad_addr", bad_addr, 0);
    check("we_in_idle", bad_idle, 0);
    check("busy_ready", bad_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
